// File: rtl/demux_lane_scheduler.sv
// Feeds a 1-to-4 byte demux from a single valid/ready source through a 1-entry hold buffer.
// Latency: at least 1 cycle from accept to Enable. Backpressure: in_ready low while a word is held; a held word is dropped after WAIT_MAX idle cycles.
module demux_lane_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int WAIT_MAX   = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mode,
  input  logic [1:0]            cfg_sel,
  input  logic [3:0]            lane_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            Sel,
  output logic                  Enable,
  output logic [3:0]            lane_valid,
  output logic                  err_drop,
  output logic [15:0]           xfer_count
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [1:0]            rr_ptr;
  logic [1:0]            sel_q;
  logic [7:0]            wait_cnt;
  logic [15:0]           xfer_q;
  logic [1:0]            target;
  logic [1:0]            scan_idx;
  logic                  can_deliver;

  // Scan descends so the lane nearest rr_ptr is the last (winning) assignment.
  always_comb begin
    target      = cfg_sel;
    can_deliver = 1'b0;
    scan_idx    = rr_ptr;
    if (mode) begin
      can_deliver = lane_ready[cfg_sel];
    end else begin
      target = rr_ptr;
      for (int i = 3; i >= 0; i--) begin
        scan_idx = rr_ptr + 2'(i);
        if (lane_ready[scan_idx]) begin
          target      = scan_idx;
          can_deliver = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    Enable    = 1'b0;
    err_drop  = 1'b0;
    case (state)
      EMPTY: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = FULL;
      end
      FULL: begin
        if (can_deliver) begin
          Enable    = 1'b1;
          state_nxt = EMPTY;
        end else if (wait_cnt == 8'(WAIT_MAX)) begin
          err_drop  = 1'b1;
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  assign data_out   = hold_q;
  assign Sel        = Enable ? target : sel_q;
  assign lane_valid = Enable ? (4'b0001 << target) : 4'b0000;
  assign xfer_count = xfer_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= EMPTY;
      hold_q   <= '0;
      rr_ptr   <= 2'd0;
      sel_q    <= 2'd0;
      wait_cnt <= 8'd0;
      xfer_q   <= 16'd0;
    end else begin
      state <= state_nxt;
      if (state == EMPTY && in_valid) hold_q <= in_data;
      if (Enable) begin
        xfer_q   <= xfer_q + 16'd1;
        sel_q    <= target;
        wait_cnt <= 8'd0;
        if (!mode) rr_ptr <= target + 2'd1;
      end else if (err_drop) begin
        wait_cnt <= 8'd0;
      end else if (state == FULL) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_demux_lane_scheduler.sv
// Scoreboarded bench for demux_lane_scheduler: directed scenarios followed by randomized traffic,
// checked every cycle against an age-based reference model.
module tb_demux_lane_scheduler;
  localparam int DW = 8;
  localparam int WM = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          mode;
  logic [1:0]    cfg_sel;
  logic [3:0]    lane_ready;
  logic [DW-1:0] data_out;
  logic [1:0]    Sel;
  logic          Enable;
  logic [3:0]    lane_valid;
  logic          err_drop;
  logic [15:0]   xfer_count;

  demux_lane_scheduler #(.DATA_WIDTH(DW), .WAIT_MAX(WM)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .cfg_sel(cfg_sel), .lane_ready(lane_ready), .data_out(data_out), .Sel(Sel),
    .Enable(Enable), .lane_valid(lane_valid), .err_drop(err_drop), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Scoreboard of accepted words awaiting delivery or drop.
  logic [DW-1:0] exp_q[$];
  int            del_lane[$];
  int            del_word[$];

  // Reference model: a held word, the cycle it was accepted, the rotation pointer and counters.
  bit armed = 0;
  bit m_full;
  int m_word, m_acc, m_ptr, m_sel, m_count;
  int cyc = 0;
  int drops = 0;
  int last_drop_cyc = 0;
  int lane, age, e_sel, e_lv;
  bit poss, e_en, e_drop;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_full = 0; m_word = 0; m_acc = 0; m_ptr = 0; m_sel = 0; m_count = 0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    poss = 0;
    lane = 0;
    if (m_full) begin
      if (mode) begin
        lane = int'(cfg_sel);
        poss = lane_ready[cfg_sel];
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (!poss && lane_ready[(m_ptr + k) % 4]) begin
            poss = 1;
            lane = (m_ptr + k) % 4;
          end
        end
      end
    end
    age    = cyc - m_acc - 1;
    e_en   = m_full && poss;
    e_drop = m_full && !poss && (age == WM);
    e_sel  = e_en ? lane : m_sel;
    e_lv   = e_en ? (1 << lane) : 0;

    if (armed) begin
      check("in_ready", int'(in_ready), int'(!m_full));
      check("enable", int'(Enable), int'(e_en));
      check("err_drop", int'(err_drop), int'(e_drop));
      check("sel", int'(Sel), e_sel);
      check("lane_valid", int'(lane_valid), e_lv);
      check("xfer_count", int'(xfer_count), m_count);
      if (m_full) check("data_out", int'(data_out), m_word);
      if (Enable) begin
        if (exp_q.size() == 0) check("sb_underflow", 1, 0);
        else check("sb_word", int'(data_out), int'(exp_q.pop_front()));
        del_lane.push_back(int'(Sel));
        del_word.push_back(int'(data_out));
      end
      if (err_drop) begin
        drops++;
        last_drop_cyc = cyc;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end

    if (reset) begin
      model_reset();
      exp_q.delete();
      armed = 1;
    end else if (!m_full) begin
      if (in_valid) begin
        m_full = 1;
        m_word = int'(in_data);
        m_acc  = cyc;
        exp_q.push_back(in_data);
      end
    end else if (e_en) begin
      m_full  = 0;
      m_count = (m_count + 1) % 65536;
      m_sel   = lane;
      if (!mode) m_ptr = (lane + 1) % 4;
    end else if (e_drop) begin
      m_full = 0;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] w);
    bit acc;
    bit done;
    done     = 0;
    in_valid = 1'b1;
    in_data  = w;
    for (int t = 0; t < 40 && !done; t++) begin
      acc = in_ready;
      tick();
      if (acc) done = 1;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  int base_drops;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; mode = 1'b0; cfg_sel = 2'd0; lane_ready = 4'h0;
    tick(); tick();
    reset = 1'b0;
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_xfer", int'(xfer_count), 0);

    // Round-robin across all-ready lanes.
    lane_ready = 4'b1111;
    del_lane.delete();
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    tick(); tick();
    check("rr_count", int'(xfer_count), 5);
    check("rr_n", del_lane.size(), 5);
    if (del_lane.size() == 5) begin
      check("rr_l0", del_lane[0], 0); check("rr_l1", del_lane[1], 1);
      check("rr_l2", del_lane[2], 2); check("rr_l3", del_lane[3], 3);
      check("rr_l4", del_lane[4], 0);
    end

    // Round-robin skips lanes that are not ready.
    lane_ready = 4'b1010;
    del_lane.delete();
    send(8'hA0); send(8'hA1); send(8'hA2);
    tick(); tick();
    check("skip_n", del_lane.size(), 3);
    if (del_lane.size() == 3) begin
      check("skip_l0", del_lane[0], 1); check("skip_l1", del_lane[1], 3);
      check("skip_l2", del_lane[2], 1);
    end

    // Fixed lane waits for its lane to come ready.
    mode = 1'b1; cfg_sel = 2'd2; lane_ready = 4'b0000;
    del_lane.delete(); del_word.delete();
    base_drops = drops;
    send(8'h5C);
    repeat (5) tick();
    lane_ready = 4'b0100;
    tick(); tick();
    check("fix_n", del_lane.size(), 1);
    if (del_lane.size() == 1) begin
      check("fix_lane", del_lane[0], 2);
      check("fix_word", del_word[0], 8'h5C);
    end
    check("fix_nodrop", drops, base_drops);

    // Timeout drop on a lane that never comes ready.
    cfg_sel = 2'd3; lane_ready = 4'b0000;
    base_drops = drops;
    send(8'hEE);
    repeat (20) tick();
    check("to_drops", drops, base_drops + 1);
    check("to_latency", last_drop_cyc - m_acc, WM + 1);
    check("to_in_ready", int'(in_ready), 1);
    check("to_count", int'(xfer_count), 9);

    // Lane comes ready on exactly the timeout cycle: delivery wins.
    base_drops = drops;
    del_lane.delete();
    send(8'hD5);
    repeat (WM) tick();
    lane_ready = 4'b1000;
    tick(); tick();
    check("race_drops", drops, base_drops);
    check("race_count", int'(xfer_count), 10);
    check("race_n", del_lane.size(), 1);
    if (del_lane.size() == 1) check("race_lane", del_lane[0], 3);

    // Reset while holding a word discards it silently.
    lane_ready = 4'b0000;
    del_word.delete();
    base_drops = drops;
    send(8'h77);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_enable", int'(Enable), 0);
    check("rst_xfer", int'(xfer_count), 0);
    check("rst_err", int'(err_drop), 0);
    lane_ready = 4'b1111;
    repeat (4) tick();
    check("rst_nodeliver", del_word.size(), 0);
    check("rst_nodrop", drops, base_drops);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      in_valid   = ($urandom_range(0, 2) != 0);
      in_data    = DW'($urandom);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 7) == 0) cfg_sel = 2'($urandom);
      lane_ready = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      if ($urandom_range(0, 40) == 0) lane_ready = 4'b0000;
      reset      = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0; in_valid = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_lane_scheduler.md
Name: demux_lane_scheduler

Overview:
- Sequencer for the 8-bit 1-to-4 demultiplexer (data, Sel, Enable → lanes A/B/C/D).
- Accepts words from one upstream source via a valid/ready handshake and holds each in a 1-entry buffer.
- Drives the demux data, Sel and Enable lines to deliver the word to a chosen lane.
- Lane choice is round-robin over ready lanes, or a fixed lane set by configuration; stale words are dropped after a timeout.

Parameters:
- DATA_WIDTH, 8, word width for in_data and data_out.
- WAIT_MAX, 15, maximum cycles a held word waits for its target lane before being dropped; legal range 1..255.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  DATA_WIDTH  upstream word.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  scheduler can accept a word.
- mode  input  1  0 = round-robin, 1 = fixed lane.
- cfg_sel  input  2  target lane when mode=1 (0=A, 1=B, 2=C, 3=D).
- lane_ready  input  4  bit i = lane i can accept a word this cycle.
- data_out  output  DATA_WIDTH  word to demux data input.
- Sel  output  2  demux select.
- Enable  output  1  demux enable; high exactly on delivery cycles.
- lane_valid  output  4  one-hot delivery strobe, equal to Enable << Sel.
- err_drop  output  1  one-cycle pulse when a word is dropped on timeout.
- xfer_count  output  16  number of words delivered since reset.

Behaviour:
- Reset values:
  - state=EMPTY, hold register=0, rr_ptr=0, wait_cnt=0.
  - in_ready=1, data_out=0, Sel=0, Enable=0, lane_valid=0, err_drop=0, xfer_count=0.
- States:
  - EMPTY: in_ready=1. When in_valid=1, latch in_data into the hold register and go to FULL. Nothing is delivered in the same cycle it is accepted (minimum latency 1 cycle from accept to Enable).
  - FULL: in_ready=0; data_out=hold register (combinational from the register).
- Target selection in FULL (combinational):
  - mode=1: target=cfg_sel; a delivery is possible when lane_ready[cfg_sel]=1.
  - mode=0: scan lanes in order rr_ptr, rr_ptr+1, ... (mod 4). Target is the first lane with lane_ready=1; a delivery is possible when any lane_ready bit is 1.
- Delivery cycle:
  - Sel=target, Enable=1, lane_valid=one-hot(target).
  - On the clock edge: return to EMPTY, xfer_count+=1 (wraps 0xFFFF→0), wait_cnt=0.
  - In mode 0, rr_ptr=target+1 mod 4. rr_ptr does not change in mode 1.
- Non-delivery cycles: Enable=0, lane_valid=0. Sel holds its last delivered value (0 after reset).
- Timeout:
  - Each FULL cycle without delivery increments wait_cnt.
  - If wait_cnt==WAIT_MAX and no delivery is possible this cycle: drop the word. err_drop=1 for that cycle, go to EMPTY, wait_cnt=0, xfer_count unchanged.
  - A delivery in the same cycle as the timeout wins; no drop occurs.
- No back-to-back acceptance: the maximum throughput is 1 word per 2 cycles.
- mode/cfg_sel changes are sampled every cycle; a change while FULL retargets the held word immediately. wait_cnt is not cleared.
- Reset asserted in any state: on the next edge all registers return to reset values and the held word is discarded without an err_drop pulse.
- Invariants:
  - Enable=1 implies state=FULL and lane_ready[Sel]=1.
  - lane_valid is always 0 or one-hot.
- in_valid while in_ready=0 is ignored; upstream must hold the word.

Test Plan:
- Reset, mode=0, lane_ready=4'b1111, send 0x11,0x22,0x33,0x44,0x55 → delivered to lanes A,B,C,D,A in order (Sel 0,1,2,3,0), each Enable 1 cycle after accept, xfer_count=5.
- mode=0, lane_ready=4'b1010, send 0xA0,0xA1,0xA2 → lanes B,D,B; ptr skips not-ready lanes.
- mode=1, cfg_sel=2, lane_ready=0 for 5 cycles then 4'b0100, word 0x5C → Enable with Sel=2 on the cycle lane C goes ready, lane_valid=4'b0100, no err_drop.
- mode=1, cfg_sel=3, lane_ready=0 permanently, WAIT_MAX=15, word 0xEE → err_drop pulses exactly once, 16 cycles after accept; in_ready returns to 1; xfer_count unchanged.
- lane_ready[D] rises on exactly the timeout cycle → delivery to D, no err_drop.
- Reset asserted while FULL with 0x77 → next cycle in_ready=1, Enable=0, xfer_count=0, err_drop=0; 0x77 is never delivered.
